sdrc_mem_responder: RTL and testbench



---
 rtl/sdrc_mem_responder_if.sv | 29 ++
 rtl/sdrc_mem_responder.sv | 149 ++++++++++++++
 tb/tb_sdrc_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdrc_mem_responder_if.sv
// rtl/sdrc_mem_responder_if.sv - application-side SDRAM request, write and read-data bundle
interface sdrc_mem_responder_if #(
  parameter int dw     = 32,
  parameter int bl     = 9,
  parameter int APP_AW = 26
);
  logic              sdr_req;
  logic [APP_AW-1:0] sdr_req_addr;
  logic [bl-1:0]     sdr_req_len;
  logic              sdr_req_wr_n;
  logic              sdr_req_ack;
  logic              sdr_busy_n;
  logic [dw/8-1:0]   sdr_wr_en_n;
  logic [dw-1:0]     sdr_wr_data;
  logic              sdr_wr_next;
  logic              sdr_rd_valid;
  logic              sdr_last_rd;
  logic [dw-1:0]     sdr_rd_data;

  modport master (
    output sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n, sdr_wr_en_n, sdr_wr_data,
    input  sdr_req_ack, sdr_busy_n, sdr_wr_next, sdr_rd_valid, sdr_last_rd, sdr_rd_data
  );

  modport slave (
    input  sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n, sdr_wr_en_n, sdr_wr_data,
    output sdr_req_ack, sdr_busy_n, sdr_wr_next, sdr_rd_valid, sdr_last_rd, sdr_rd_data
  );
endinterface

// File: rtl/sdrc_mem_responder.sv
// rtl/sdrc_mem_responder.sv - SDRAM controller stand-in serving bursts from a byte-maskable array
module sdrc_mem_responder #(
  parameter int dw      = 32,
  parameter int bl      = 9,
  parameter int APP_AW  = 26,
  parameter int MEM_AW  = 10,
  parameter int RD_LAT  = 2,
  parameter int REF_INT = 0,
  parameter int REF_CYC = 4
) (
  input  logic                sdram_clk,
  input  logic                sdram_resetn,
  sdrc_mem_responder_if.slave sdr
);
  localparam int NB    = dw / 8;
  localparam int DLY_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_REF, S_ACK, S_WRITE, S_RDWAIT, S_READ} state_e;

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [bl-1:0]     rem_q, rem_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ref_expire;
  logic              ack_q, busy_n_q, wr_next_q, rd_valid_q, last_q, last_d;
  logic [dw-1:0]     rd_data_q, rd_data_d;
  logic              unused_addr_hi;

  logic [dw-1:0] mem [0:(1<<MEM_AW)-1];

  assign unused_addr_hi = ^sdr.sdr_req_addr[APP_AW-1:MEM_AW];

  generate
    if (REF_INT > 0) begin : g_ref
      logic [31:0] ref_cnt_q;
      always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn)         ref_cnt_q <= 32'(REF_INT - 1);
        else if (ref_cnt_q == '0)  ref_cnt_q <= 32'(REF_INT - 1);
        else                       ref_cnt_q <= ref_cnt_q - 32'd1;
      end
      assign ref_expire = (ref_cnt_q == '0);
    end else begin : g_noref
      assign ref_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    dly_d      = dly_q;
    ref_pend_d = ref_pend_q | ref_expire;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          state_d = S_REF;
          dly_d   = DLY_W'(REF_CYC - 1);
        end else if (sdr.sdr_req) begin
          state_d = S_ACK;
        end
      end
      S_REF: begin
        if (dly_q == '0) begin
          state_d    = S_IDLE;
          ref_pend_d = ref_expire;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      S_ACK: begin
        addr_d = sdr.sdr_req_addr[MEM_AW-1:0];
        rem_d  = (sdr.sdr_req_len == '0) ? bl'(1) : sdr.sdr_req_len;
        if (!sdr.sdr_req_wr_n) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_RDWAIT;
          dly_d   = DLY_W'(RD_LAT - 1);
        end
      end
      S_WRITE: begin
        addr_d = addr_q + MEM_AW'(1);
        rem_d  = rem_q - bl'(1);
        if (rem_q == bl'(1)) state_d = S_IDLE;
      end
      S_RDWAIT: begin
        if (dly_q == '0) state_d = S_READ;
        else             dly_d   = dly_q - DLY_W'(1);
      end
      S_READ: begin
        if (rem_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every edge landing in READ fetches one beat; rem_q counts beats not yet fetched.
    rd_data_d = '0;
    last_d    = 1'b0;
    if (state_d == S_READ) begin
      rd_data_d = mem[addr_q];
      last_d    = (rem_q == bl'(1));
      addr_d    = addr_q + MEM_AW'(1);
      rem_d     = rem_q - bl'(1);
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      dly_q      <= '0;
      ref_pend_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_n_q   <= 1'b1;
      wr_next_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      last_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dly_q      <= dly_d;
      ref_pend_q <= ref_pend_d;
      ack_q      <= (state_d == S_ACK);
      busy_n_q   <= (state_d == S_IDLE);
      wr_next_q  <= (state_d == S_WRITE);
      rd_valid_q <= (state_d == S_READ);
      last_q     <= last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (state_q == S_WRITE) begin
      for (int k = 0; k < NB; k++) begin
        if (!sdr.sdr_wr_en_n[k]) mem[addr_q][8*k +: 8] <= sdr.sdr_wr_data[8*k +: 8];
      end
    end
  end

  assign sdr.sdr_req_ack  = ack_q;
  assign sdr.sdr_busy_n   = busy_n_q;
  assign sdr.sdr_wr_next  = wr_next_q;
  assign sdr.sdr_rd_valid = rd_valid_q;
  assign sdr.sdr_last_rd  = last_q;
  assign sdr.sdr_rd_data  = rd_data_q;
endmodule

// File: tb/tb_sdrc_mem_responder.sv
// tb/tb_sdrc_mem_responder.sv - directed self-checking bench for sdrc_mem_responder
module tb_sdrc_mem_responder;
  localparam int DW  = 32;
  localparam int BL  = 9;
  localparam int AAW = 26;
  localparam int MAW = 4;
  localparam int N   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_v = '0;
  logic [AAW-1:0] addr;
  logic [BL-1:0]  len;
  logic           wr_n;
  logic [3:0]     wen_n;
  logic [31:0]    wdata;

  wire [N-1:0] ack_v, busy_v, wnext_v, rvalid_v, last_v;
  wire [31:0]  rdata_v [N];

  // Instance 0: RD_LAT 2; 1: RD_LAT 1; 2: RD_LAT 5; 3: RD_LAT 2 with refresh every 20 cycles.
  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int LAT  = (g == 1) ? 1 : (g == 2) ? 5 : 2;
      localparam int RINT = (g == 3) ? 20 : 0;
      sdrc_mem_responder_if #(.dw(DW), .bl(BL), .APP_AW(AAW)) bus ();
      assign bus.sdr_req      = req_v[g];
      assign bus.sdr_req_addr = addr;
      assign bus.sdr_req_len  = len;
      assign bus.sdr_req_wr_n = wr_n;
      assign bus.sdr_wr_en_n  = wen_n;
      assign bus.sdr_wr_data  = wdata;
      assign ack_v[g]    = bus.sdr_req_ack;
      assign busy_v[g]   = bus.sdr_busy_n;
      assign wnext_v[g]  = bus.sdr_wr_next;
      assign rvalid_v[g] = bus.sdr_rd_valid;
      assign last_v[g]   = bus.sdr_last_rd;
      assign rdata_v[g]  = bus.sdr_rd_data;
      sdrc_mem_responder #(
        .dw(DW), .bl(BL), .APP_AW(AAW), .MEM_AW(MAW),
        .RD_LAT(LAT), .REF_INT(RINT), .REF_CYC(4)
      ) u_dut (
        .sdram_clk   (clk),
        .sdram_resetn(rst_n),
        .sdr         (bus)
      );
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wdat [8];
  logic [3:0]  wmsk [8];
  logic [31:0] edat [8];
  int sw_d   [3] = '{1, 0, 2};
  int sw_lat [3] = '{1, 2, 5};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [AAW-1:0] a, input logic [BL-1:0] l, input logic w_n);
    int t;
    addr     = a;
    len      = l;
    wr_n     = w_n;
    req_v[d] = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!ack_v[d] && t < 50);
    chk("ack_seen", ack_v[d], 1);
    req_v[d] = 1'b0;
  endtask

  task automatic wr_burst(input int d, input logic [AAW-1:0] a, input int n);
    issue(d, a, BL'(n), 1'b0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("wr_next", wnext_v[d], 1);
      wdata = wdat[i];
      wen_n = wmsk[i];
    end
    tick();
    chk("wr_done_next", wnext_v[d], 0);
    chk("wr_done_busy", busy_v[d], 1);
    wen_n = 4'hF;
  endtask

  task automatic rd_burst(input int d, input logic [AAW-1:0] a, input logic [BL-1:0] l,
                          input int n, input int lat);
    issue(d, a, l, 1'b1);
    for (int c = 0; c < lat; c++) begin
      tick();
      chk("rd_wait_valid", rvalid_v[d], 0);
    end
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rd_valid", rvalid_v[d], 1);
      chk("rd_data", rdata_v[d], edat[i]);
      chk("rd_last", last_v[d], (i == n - 1));
    end
    tick();
    chk("rd_end_valid", rvalid_v[d], 0);
    chk("rd_end_data", rdata_v[d], 0);
    chk("rd_end_busy", busy_v[d], 1);
  endtask

  initial begin
    int acks, rvs, last_ack, ref_runs, run, run_ack, bad_gap, bad_run, gap10;
    addr = '0; len = '0; wr_n = 1'b1; wen_n = 4'hF; wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_n", busy_v[0], 1);
    chk("rst_ack", ack_v[0], 0);
    chk("rst_wr_next", wnext_v[0], 0);
    chk("rst_rd_valid", rvalid_v[0], 0);
    chk("rst_last", last_v[0], 0);
    chk("rst_rd_data", rdata_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    wdat[0] = 32'hDEADBEEF; wmsk[0] = 4'h0;
    wr_burst(0, 26'h5, 1);
    edat[0] = 32'hDEADBEEF;
    rd_burst(0, 26'h5, 9'd0, 1, 2);

    wdat[0] = 32'hFFFFFFFF; wmsk[0] = 4'h0;
    wr_burst(0, 26'h3, 1);
    wdat[0] = 32'h00000000; wmsk[0] = 4'b1010;
    wr_burst(0, 26'h3, 1);
    edat[0] = 32'hFF00FF00;
    rd_burst(0, 26'h3, 9'd1, 1, 2);
    rd_burst(0, 26'h1000003, 9'd1, 1, 2);

    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'(i + 1);
      wmsk[i] = 4'h0;
      edat[i] = 32'(i + 1);
    end
    wr_burst(0, 26'hE, 4);
    rd_burst(0, 26'hE, 9'd4, 4, 2);
    edat[0] = 32'd3; edat[1] = 32'd4;
    rd_burst(0, 26'h0, 9'd2, 2, 2);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        wdat[i] = 32'hA0000000 | 32'(k << 8) | 32'(i);
        wmsk[i] = 4'h0;
        edat[i] = wdat[i];
      end
      wr_burst(sw_d[k], 26'h8, 3);
      rd_burst(sw_d[k], 26'h8, 9'd3, 3, sw_lat[k]);
    end

    wdat[0] = 32'h12345678; wmsk[0] = 4'h0;
    wr_burst(3, 26'h0, 1);
    addr = '0; len = 9'd1; wr_n = 1'b1;
    req_v[3] = 1'b1;
    acks = 0; rvs = 0; last_ack = -1; ref_runs = 0; run = 0; run_ack = 0;
    bad_gap = 0; bad_run = 0; gap10 = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (ack_v[3]) begin
        if (last_ack >= 0) begin
          if (c - last_ack == 10)     gap10++;
          else if (c - last_ack != 5) bad_gap++;
        end
        last_ack = c;
        acks++;
      end
      if (rvalid_v[3]) begin
        rvs++;
        chk("ref_rd_data", rdata_v[3], 32'h12345678);
      end
      if (!busy_v[3]) begin
        run++;
        if (ack_v[3]) run_ack = 1;
      end else if (run > 0) begin
        if (run != 4) bad_run++;
        if (run_ack == 0) ref_runs++;
        run = 0;
        run_ack = 0;
      end
    end
    req_v[3] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack_v[3])    acks++;
      if (rvalid_v[3]) rvs++;
    end
    chk("ref_reads_eq_acks", 64'(rvs), 64'(acks));
    chk("ref_ack_gaps", 64'(bad_gap), 0);
    chk("ref_busy_runs", 64'(bad_run), 0);
    chk("ref_run_count", (ref_runs >= 5 && ref_runs <= 7), 1);
    chk("ref_gap10_count", (gap10 >= 4), 1);

    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'h11111111 * 32'(i + 1);
      wmsk[i] = 4'h0;
      edat[i] = wdat[i];
    end
    wr_burst(0, 26'h4, 4);
    issue(0, 26'h4, 9'd4, 1'b1);
    repeat (2) tick();
    tick();
    chk("rst_mid_beat1", rvalid_v[0], 1);
    tick();
    chk("rst_mid_beat2", rdata_v[0], edat[1]);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rvalid_v[0], 0);
    chk("rst_mid_last", last_v[0], 0);
    chk("rst_mid_busy", busy_v[0], 1);
    chk("rst_mid_data", rdata_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", rvalid_v[0], 0);
    wdat[0] = 32'hCAFEF00D; wmsk[0] = 4'h0;
    wr_burst(0, 26'h2, 1);
    edat[0] = 32'hCAFEF00D;
    rd_burst(0, 26'h2, 9'd1, 1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
